// File: rtl/contador_hex_multiplexado.sv
// contador_hex_multiplexado: prescaled N-digit hex up/down counter with multiplexed active-low 7-seg scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module contador_hex_multiplexado #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 4
) (
  input  logic                  clock_50mhz,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic [6:0]            segmentos,
  output logic [DIGITS-1:0]     anodo
);
  localparam int PDIV = CLK_HZ / TICK_HZ;
  localparam int SDIV = CLK_HZ / SCAN_HZ;
  localparam int PW = $clog2(PDIV);
  localparam int SW = $clog2(SDIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [PW-1:0] pre;
  logic [SW-1:0] sdiv;
  logic [IW-1:0] idx;
  logic          pre_end, scan_end, blank;
  logic [3:0]    nib;
  assign pre_end  = pre == PW'(PDIV - 1);
  assign scan_end = sdiv == SW'(SDIV - 1);
  assign nib      = count[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (idx != '0) && ((count >> (4*idx)) == '0);
`else
  assign blank = 1'b0;
`endif
  // Adding all-ones steps the count down by one modulo 2^(4*DIGITS).
  always_ff @(posedge clock_50mhz) begin
    if (!reset_n) begin
      pre   <= '0;
      tick  <= 1'b0;
      count <= '0;
    end else begin
      tick  <= enable && pre_end && !load;
      pre   <= load ? '0 : !enable ? pre : pre_end ? '0 : pre + 1'b1;
      count <= load ? load_value
             : (enable && pre_end) ? count + {{(4*DIGITS-1){~up_down}}, 1'b1}
             : count;
    end
  end
  always_ff @(posedge clock_50mhz) begin
    if (!reset_n) begin
      sdiv      <= '0;
      idx       <= '0;
      anodo     <= ~DIGITS'(1);
      segmentos <= 7'h40;
    end else begin
      sdiv      <= scan_end ? '0 : sdiv + 1'b1;
      idx       <= !scan_end ? idx : (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      anodo     <= ~(DIGITS'(1) << idx);
      segmentos <= blank ? 7'h7F : GLYPH[nib];
    end
  end
endmodule
